// File: rtl/multiplier_request_driver_if.sv
// Request/result bundle between the multiplier request driver and its environment.
// The MULT_RESULT_CHECK_EN macro adds the rsp_mismatch signal.
interface multiplier_request_driver_if #(
  parameter int P = 7
);
  localparam int P2 = ((P + 1) / 2) - 1;
  localparam int P3 = ((P + 1) / 4) - 1;

  logic          req_valid;
  logic          req_ready;
  logic [P3:0]   op_a;
  logic [P3:0]   op_b;
  logic          clamp_en;
  logic [P2:0]   clamp_val;
  logic          pending_request;
  logic [P2:0]   result;
  logic          valid_res;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [P2:0]   rsp_data;
  logic          rsp_err;
`ifdef MULT_RESULT_CHECK_EN
  logic          rsp_mismatch;
`endif

  modport master (
    input  req_valid,
    input  op_a,
    input  op_b,
    input  result,
    input  valid_res,
    input  rsp_ready,
    output req_ready,
    output clamp_en,
    output clamp_val,
    output pending_request,
    output rsp_valid,
    output rsp_data,
    output rsp_err
`ifdef MULT_RESULT_CHECK_EN
    ,
    output rsp_mismatch
`endif
  );

  modport slave (
    output req_valid,
    output op_a,
    output op_b,
    output result,
    output valid_res,
    output rsp_ready,
    input  req_ready,
    input  clamp_en,
    input  clamp_val,
    input  pending_request,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_err
`ifdef MULT_RESULT_CHECK_EN
    ,
    input  rsp_mismatch
`endif
  );

endinterface

// File: rtl/multiplier_request_driver.sv
// Initiator for the p-bit multiplier request/result protocol.
// Define MULT_RESULT_CHECK_EN to add the rsp_mismatch product check.
module multiplier_request_driver #(
  parameter int P              = 7,
  parameter int SETTLE_CYCLES  = 12,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic CLK,
  input  logic RST_N,
  multiplier_request_driver_if.master bus
);

  localparam int P2 = ((P + 1) / 2) - 1;
  localparam int P3 = ((P + 1) / 4) - 1;
  localparam int DW = P2 + 1;
  localparam int OW = P3 + 1;
  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RUN,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic          rst_n;
  logic [1:0]    rst_sync_q;

  logic          req_ready_q, req_ready_d;
  logic          clamp_en_q, clamp_en_d;
  logic          pend_q, pend_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic [OW-1:0] op_a_q, op_a_d;
  logic [OW-1:0] op_b_q, op_b_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  logic accept;
  logic in_settle;
  logic in_run;
  logic rsp_done;
  logic expire;

`ifdef MULT_RESULT_CHECK_EN
  logic          mm_q, mm_d;
  logic [DW-1:0] prod;

  assign prod = DW'(op_a_q) * DW'(op_b_q);
`endif

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  assign accept    = (state_q == IDLE) && bus.req_valid && req_ready_q;
  assign in_settle = (state_q == SETTLE);
  assign in_run    = (state_q == RUN);
  assign rsp_done  = (state_q == RESP) && rsp_valid_q && bus.rsp_ready;
  assign expire    = (to_cnt_q == TO_LAST);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) state_d = RUN;
      end
      RUN: begin
        if (bus.valid_res || expire) state_d = RESP;
      end
      RESP: begin
        if (rsp_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_d  = (state_d == IDLE);
    clamp_en_d   = (state_d == SETTLE) || (state_d == RUN);
    pend_d       = (state_d == RUN);
    rsp_valid_d  = (state_d == RESP);
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    settle_cnt_d = '0;
    to_cnt_d     = '0;
`ifdef MULT_RESULT_CHECK_EN
    mm_d         = mm_q;
`endif
    unique case (1'b1)
      accept: begin
        op_a_d = bus.op_a;
        op_b_d = bus.op_b;
      end
      in_settle: begin
        settle_cnt_d = settle_cnt_q + SW'(1);
      end
      in_run: begin
        to_cnt_d = to_cnt_q + TW'(1);
        // A pulse on the expiry cycle still counts as success.
        if (bus.valid_res) begin
          rsp_data_d = bus.result;
          rsp_err_d  = 1'b0;
`ifdef MULT_RESULT_CHECK_EN
          mm_d       = (prod != bus.result);
`endif
        end else if (expire) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
`ifdef MULT_RESULT_CHECK_EN
          mm_d       = 1'b0;
`endif
        end
      end
      rsp_done: begin
`ifdef MULT_RESULT_CHECK_EN
        mm_d = 1'b0;
`endif
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_q  <= 1'b1;
      clamp_en_q   <= 1'b0;
      pend_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      settle_cnt_q <= '0;
      to_cnt_q     <= '0;
`ifdef MULT_RESULT_CHECK_EN
      mm_q         <= 1'b0;
`endif
    end else begin
      req_ready_q  <= req_ready_d;
      clamp_en_q   <= clamp_en_d;
      pend_q       <= pend_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      settle_cnt_q <= settle_cnt_d;
      to_cnt_q     <= to_cnt_d;
`ifdef MULT_RESULT_CHECK_EN
      mm_q         <= mm_d;
`endif
    end
  end

  assign bus.req_ready       = req_ready_q;
  assign bus.clamp_en        = clamp_en_q;
  assign bus.clamp_val       = DW'({op_a_q, op_b_q});
  assign bus.pending_request = pend_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_data        = rsp_data_q;
  assign bus.rsp_err         = rsp_err_q;
`ifdef MULT_RESULT_CHECK_EN
  assign bus.rsp_mismatch    = mm_q;
`endif

endmodule

// File: tb/tb_multiplier_request_driver.sv
// Testbench for multiplier_request_driver: vector table, reset abort and
// randomized transactions against a transaction-level reference model.
module tb_multiplier_request_driver;

  localparam int S  = 12;
  localparam int TO = 32;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  multiplier_request_driver_if #(.P(7)) bus ();

  multiplier_request_driver #(
    .P              (7),
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int n;
    int res;
    int hold;
    bit stale;
    int ed;
    int ee;
    int el;
    int ep;
    int emm;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Outcome of one transaction from the protocol rules: a pulse in
  // RUN cycle 1..TO wins, anything else is a timeout after TO cycles.
  function automatic void model(input int a, input int b, input int n,
                                input int res, output int d,
                                output int e, output int lat,
                                output int pend, output int mm);
    if (n >= 1 && n <= TO) begin
      d    = res;
      e    = 0;
      lat  = S + n;
      pend = n;
      mm   = (((a * b) % 16) != res) ? 1 : 0;
    end else begin
      d    = 0;
      e    = 1;
      lat  = S + TO;
      pend = TO;
      mm   = 0;
    end
  endfunction

  function automatic logic mm_out();
`ifdef MULT_RESULT_CHECK_EN
    return bus.rsp_mismatch;
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_txn(input int a, input int b, input int n,
                         input int res, input int hold, input bit stale,
                         output int d, output int e, output int mm,
                         output int lat, output int pend,
                         output bit side_ok, output bit hs_ok);
    int c;
    int w;
    bit ok;
    logic [3:0] d0;
    logic e0;
    logic [3:0] cv;
    cv = 4'((a % 4) * 4 + (b % 4));
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
    bus.op_a = 2'(a);
    bus.op_b = 2'(b);
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.op_a = 2'(~a);
    bus.op_b = 2'(~b);
    c = 0;
    pend = 0;
    ok = 1'b1;
    while (c <= S + TO + 5) begin
      if (bus.rsp_valid === 1'b1) break;
      if (bus.pending_request === 1'b1) pend++;
      if (bus.clamp_en !== 1'b1 || bus.clamp_val !== cv ||
          bus.req_ready !== 1'b0) ok = 1'b0;
      bus.valid_res = (n > 0 && c == S + n - 1) || (stale && c == 3);
      bus.result = (stale && c == 3) ? 4'hF : 4'(res);
      @(posedge clk); #1;
      bus.valid_res = 1'b0;
      c++;
    end
    lat = c;
    d = int'(bus.rsp_data);
    e = int'(bus.rsp_err);
    mm = int'(mm_out());
    if (bus.pending_request !== 1'b0 || bus.clamp_en !== 1'b0) ok = 1'b0;
    d0 = bus.rsp_data;
    e0 = bus.rsp_err;
    for (int h = 0; h < hold; h++) begin
      bus.valid_res = stale && (h == 0);
      bus.result = 4'hF;
      @(posedge clk); #1;
      bus.valid_res = 1'b0;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d0 ||
          bus.rsp_err !== e0 || bus.req_ready !== 1'b0) ok = 1'b0;
    end
    side_ok = ok;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    hs_ok = (bus.rsp_valid === 1'b0) && (bus.req_ready === 1'b1) &&
            (bus.clamp_en === 1'b0) && (mm_out() === 1'b0);
    @(posedge clk); #1;
    hs_ok = hs_ok && (bus.req_ready === 1'b1) && (bus.clamp_en === 1'b0);
  endtask

  initial begin
    int d, e, mm, lat, pend;
    int ed, ee, el, ep, emm;
    int a, b, n, res, hold;
    bit stale, side_ok, hs_ok;
    string t;

    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.result = '0;
    bus.valid_res = 1'b0;
    bus.rsp_ready = 1'b0;

    tbl[0] = '{3, 3, 20,  9,  0, 1'b0,  9, 0, 32, 20, 0};
    tbl[1] = '{1, 1,  0,  7,  0, 1'b0,  0, 1, 44, 32, 0};
    tbl[2] = '{2, 3,  7,  6,  0, 1'b1,  6, 0, 19,  7, 0};
    tbl[3] = '{1, 2,  5,  2, 10, 1'b1,  2, 0, 17,  5, 0};
    tbl[4] = '{2, 2,  3,  5,  0, 1'b0,  5, 0, 15,  3, 1};
    tbl[5] = '{2, 2,  3,  4,  0, 1'b0,  4, 0, 15,  3, 0};
    tbl[6] = '{0, 1, 32, 11,  0, 1'b0, 11, 0, 44, 32, 1};
    tbl[7] = '{3, 2,  1,  6,  0, 1'b0,  6, 0, 13,  1, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_clamp_en", 32'(bus.clamp_en), 32'd0);
    chk("rst_clamp_val", 32'(bus.clamp_val), 32'd0);
    chk("rst_pending", 32'(bus.pending_request), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].a, tbl[i].b, tbl[i].n, tbl[i].res, tbl[i].hold,
              tbl[i].stale, d, e, mm, lat, pend, side_ok, hs_ok);
      t = $sformatf("v%0d", i);
      chk({t, "_data"}, 32'(d), 32'(tbl[i].ed));
      chk({t, "_err"}, 32'(e), 32'(tbl[i].ee));
      chk({t, "_lat"}, 32'(lat), 32'(tbl[i].el));
      chk({t, "_pend"}, 32'(pend), 32'(tbl[i].ep));
      chk({t, "_side"}, 32'(side_ok), 32'd1);
      chk({t, "_hs"}, 32'(hs_ok), 32'd1);
`ifdef MULT_RESULT_CHECK_EN
      chk({t, "_mm"}, 32'(mm), 32'(tbl[i].emm));
`endif
    end

    // Reset in the middle of RUN must drop everything at once.
    bus.op_a = 2'd3;
    bus.op_b = 2'd1;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (S + 3) @(posedge clk);
    #1;
    chk("t1_pending_before", 32'(bus.pending_request), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_pending", 32'(bus.pending_request), 32'd0);
    chk("t1_clamp_en", 32'(bus.clamp_en), 32'd0);
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t1_req_ready", 32'(bus.req_ready), 32'd1);
    chk("t1_clamp_val", 32'(bus.clamp_val), 32'd0);

    for (int i = 0; i < 16; i++) begin
      a = int'($urandom_range(0, 3));
      b = int'($urandom_range(0, 3));
      n = int'($urandom_range(0, TO + 3));
      res = int'($urandom_range(0, 15));
      hold = int'($urandom_range(0, 4));
      stale = 1'($urandom_range(0, 1));
      if (i % 3 == 0) res = (a * b) % 16;
      model(a, b, n, res, ed, ee, el, ep, emm);
      run_txn(a, b, n, res, hold, stale, d, e, mm, lat, pend,
              side_ok, hs_ok);
      t = $sformatf("r%0d", i);
      chk({t, "_data"}, 32'(d), 32'(ed));
      chk({t, "_err"}, 32'(e), 32'(ee));
      chk({t, "_lat"}, 32'(lat), 32'(el));
      chk({t, "_pend"}, 32'(pend), 32'(ep));
      chk({t, "_side"}, 32'(side_ok), 32'd1);
      chk({t, "_hs"}, 32'(hs_ok), 32'd1);
`ifdef MULT_RESULT_CHECK_EN
      chk({t, "_mm"}, 32'(mm), 32'(emm));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
